// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
// The serial line is driven straight from a flop so the pin never glitches.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;

  assign bit_end    = (baud_q == BAUD_LAST);
  assign data_ready = (state_q == IDLE);
  assign busy       = ~data_ready;
  assign tx         = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    // Baud counter free-runs in every non-idle state and wraps on the boundary cycle.
    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (data_valid) begin
          state_d = START;
          tx_d    = 1'b0;
          shift_d = data_in;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
            bit_d   = '0;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_q == STOP_LAST) state_d = IDLE;
          else                    bit_d   = bit_q + BIT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (4 clocks/bit) and a 115200-baud
// instance with two stop bits decoded by a mid-bit sampling receive model.
module tb_uart_tx;
  localparam int C  = 4;
  localparam int C6 = 868;

  logic       clock, reset;
  logic [7:0] din, d6;
  logic       dv, v6;
  logic       rdy, txo, bsy;
  logic       rdy6, tx6, bsy6;
  int         checks, errors;

  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clock(clock), .reset(reset), .data_in(din), .data_valid(dv),
    .data_ready(rdy), .tx(txo), .busy(bsy)
  );

  uart_tx #(.CLKS_PER_BIT(C6), .DATA_BITS(8), .STOP_BITS(2)) dut6 (
    .clock(clock), .reset(reset), .data_in(d6), .data_valid(v6),
    .data_ready(rdy6), .tx(tx6), .busy(bsy6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called on the sample point just after the handshake edge; walks the whole frame.
  task automatic check_frame(input logic [7:0] b, input bit noise);
    logic expb;
    int   j;
    for (int i = 0; i < 10 * C; i++) begin
      j = i / C;
      if (j == 0)      expb = 1'b0;
      else if (j == 9) expb = 1'b1;
      else             expb = b[j-1];
      chk("frame_tx", {31'd0, txo}, {31'd0, expb});
      chk("frame_ready", {31'd0, rdy}, 32'd0);
      if (noise) begin
        din = 8'($urandom);
        dv  = 1'($urandom);
      end
      tick(1);
    end
    if (noise) dv = 1'b0;
    chk("end_ready", {31'd0, rdy}, 32'd1);
    chk("end_busy", {31'd0, bsy}, 32'd0);
    chk("end_tx", {31'd0, txo}, 32'd1);
  endtask

  logic [7:0] rx_byte;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    dv = 1'b0; din = 8'h00;
    v6 = 1'b0; d6  = 8'h00;
    #1;
    chk("rst_tx", {31'd0, txo}, 32'd1);
    chk("rst_ready", {31'd0, rdy}, 32'd1);
    chk("rst_busy", {31'd0, bsy}, 32'd0);
    tick(3);
    reset = 1'b0;

    // Idle with no stimulus
    for (int i = 0; i < 100; i++) begin
      chk("idle_tx", {31'd0, txo}, 32'd1);
      chk("idle_ready", {31'd0, rdy}, 32'd1);
      chk("idle_busy", {31'd0, bsy}, 32'd0);
      tick(1);
    end

    // Single 0x55 frame
    din = 8'h55; dv = 1'b1;
    tick(1);
    dv = 1'b0;
    chk("busy_after_hs", {31'd0, bsy}, 32'd1);
    check_frame(8'h55, 1'b0);

    // Back-to-back 0x00 then 0xFF with data_valid held
    tick(2);
    din = 8'h00; dv = 1'b1;
    tick(1);
    din = 8'hFF;
    check_frame(8'h00, 1'b0);
    tick(1);
    dv = 1'b0;
    check_frame(8'hFF, 1'b0);

    // 0xA3 with noisy inputs during the frame
    tick(3);
    din = 8'hA3; dv = 1'b1;
    tick(1);
    check_frame(8'hA3, 1'b1);

    // Reset in the third data bit of 0x0F aborts the frame
    tick(2);
    din = 8'h0F; dv = 1'b1;
    tick(1);
    dv = 1'b0;
    tick(C + 2 * C + 1);
    chk("mid_busy", {31'd0, bsy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_tx", {31'd0, txo}, 32'd1);
    chk("abort_ready", {31'd0, rdy}, 32'd1);
    chk("abort_busy", {31'd0, bsy}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("post_rst_tx", {31'd0, txo}, 32'd1);
    din = 8'h81; dv = 1'b1;
    tick(1);
    dv = 1'b0;
    check_frame(8'h81, 1'b0);

    // 868 clocks/bit, 2 stop bits, 0xC6 decoded by a mid-bit receive model
    d6 = 8'hC6; v6 = 1'b1;
    tick(1);
    v6 = 1'b0;
    d6 = 8'h00;
    chk("c6_fall", {31'd0, tx6}, 32'd0);
    tick(C6 - 1);
    chk("c6_start_last", {31'd0, tx6}, 32'd0);
    tick(1);
    chk("c6_bit0_first", {31'd0, tx6}, 32'd0);
    tick(C6 / 2 - C6);
    rx_byte = 8'h00;
    tick(C6 / 2 + C6 / 2 - C6 / 2);
    // now at mid of bit 0 (start fall + 1.5 bits)
    for (int k = 0; k < 8; k++) begin
      rx_byte[k] = tx6;
      chk("c6_busy", {31'd0, bsy6}, 32'd1);
      tick(C6);
    end
    chk("c6_rx_byte", {24'd0, rx_byte}, 32'h0000_00C6);
    chk("c6_stop1", {31'd0, tx6}, 32'd1);
    tick(C6);
    chk("c6_stop2", {31'd0, tx6}, 32'd1);
    chk("c6_ready_early", {31'd0, rdy6}, 32'd0);
    tick(C6 / 2 - 1);
    chk("c6_ready_last_busy", {31'd0, rdy6}, 32'd0);
    tick(1);
    chk("c6_ready", {31'd0, rdy6}, 32'd1);
    chk("c6_idle_tx", {31'd0, tx6}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
